// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, fixed XLEN-cycle latency.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are applied at the end.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic              div0_q, div0_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Operand sign handling at capture time.
   logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   assign is_div = funct3[2];
   assign a_sgn  = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
   assign b_sgn  = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
   assign a_neg  = a_sgn & op_a[XLEN-1];
   assign b_neg  = b_sgn & op_b[XLEN-1];
   // An unsigned XLEN-bit magnitude holds 2^(XLEN-1), so the most negative operand never overflows.
   assign a_mag  = a_neg ? -op_a : op_a;
   assign b_mag  = b_neg ? -op_b : op_b;

   // acc_q: multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient}.
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN-1:0]   div_sub;
   logic              div_ge;
   logic [2*XLEN-1:0] acc_step;

   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
   assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, mcand_q};
   assign div_sub   = div_shift[XLEN-1:0] - mcand_q;
   assign acc_step  = f3_q[2] ? (div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                                        : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0})
                              : {mul_sum, acc_q[XLEN-1:1]};

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, final_res;

   assign prod = neg_q ? -acc_step : acc_step;
   assign quo  = acc_step[XLEN-1:0];
   assign rem  = acc_step[2*XLEN-1:XLEN];

   always_comb begin
      final_res = prod[XLEN-1:0];
      case (f3_q)
         3'b000:                 final_res = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = div0_q ? {XLEN{1'b1}} : (neg_q ? -quo : quo);
         default:                final_res = rneg_q ? -rem : rem;
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      result_d = result_q;
      if (flush) begin
         state_d = S_IDLE;
      end else if (state_q == S_CALC) begin
         acc_d = acc_step;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d  = S_DONE;
            result_d = final_res;
         end
      end else if (start) begin
         state_d = S_CALC;
         cnt_d   = '0;
         f3_d    = funct3;
         mcand_d = is_div ? b_mag : a_mag;
         acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
         neg_d   = a_neg ^ b_neg;
         rneg_d  = a_neg;
         div0_d  = (op_b == '0);
      end else begin
         state_d = S_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == S_CALC);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read values (op_a = rs1 data, op_b = rs2 data) plus funct3 from the decoder.
- Produces a 32-bit result for the writeback mux; the controller stalls the pipeline on busy.
- One bit is processed per cycle, giving a fixed latency for every operation.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin operation; sampled on rising edge
flush  input  1  synchronous kill of in-flight operation (pipeline flush)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 operand (multiplicand / dividend)
op_b  input  XLEN  rs2 operand (multiplier / divisor)
busy  output  1  high while iterating
done  output  1  one-cycle pulse; result valid
result  output  XLEN  operation result; held until next accepted start

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n); state=IDLE, busy=0, done=0, result=0, all internal registers cleared; takes effect immediately, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE/DONE + start=1 (flush=0) -> capture funct3, op_a, op_b; iteration counter=0; go to CALC.
  - Later changes on op_a, op_b or funct3 are ignored.
  - In DONE, done is still asserted that cycle (back-to-back issue allowed).
- IDLE/DONE + start=0 -> IDLE.
- CALC: busy=1; one iteration per edge; counter increments; after XLEN iterations go to DONE.
  - Start is sampled at edge E0; CALC covers edges E1..E32; done=1 in the cycle after E32.
  - start asserted during CALC is ignored (no queueing).
- DONE: done=1 for exactly one cycle, busy=0, result registered and valid; result stays stable until the next accepted start.
- flush=1: in any state -> IDLE at next edge; done stays 0; result keeps its prior value; flush has priority over start.
- Multiply:
  - shift-add on magnitudes with a 2*XLEN product.
  - Signed operands: MULH both; MULHSU op_a only; MUL/MULHU none (MUL low half is sign-agnostic).
  - Negate the product if operand signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring division on magnitudes (signed for DIV/REM, raw for DIVU/REMU).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a); result satisfies a = q*b + r.
- Boundary cases; these are required outputs at the same fixed latency, no early-out:
  - divisor=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - Operand magnitude 0x80000000 must be handled as 2^31 without overflow (internal magnitude width XLEN+1 or equivalent).
- No arithmetic exceptions are raised.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB.
  - done pulses exactly one cycle, 32 edges after the start edge.
  - busy=1 for the 32 CALC cycles.
- High-half multiplies -> results:
  - MULH 0x80000000*0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
- Signed divide -> results:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF
  - DIVU 100/7 -> 14
  - REMU 100/7 -> 2
- Divide edge cases -> results:
  - DIV 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM 0x80000000/0xFFFFFFFF -> 0
- Control corner cases:
  - start mid-CALC with new operands -> ignored; the original result is delivered.
  - flush at iteration 10 -> no done pulse, IDLE next cycle, result unchanged.
  - start asserted in the DONE cycle -> new op accepted; second done pulse 32 edges later.
- Reset:
  - rst_n low mid-CALC -> busy, done and result go to 0 immediately (asynchronously).
  - After release, a new MULHU 3*5 -> done with result 0.
